// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl_if
// Description : Execute-stage request, multdiv handshake and writeback bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_issue_ctrl_if;
  logic        req_valid;
  logic        req_is_div;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  modport master (
    output req_valid, req_is_div, req_a, req_b, req_rd, flush,
    output md_result, md_exception, md_resultRDY,
    input  stall, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  wb_valid, wb_rd, wb_data, wb_exception
  );

  modport slave (
    input  req_valid, req_is_div, req_a, req_b, req_rd, flush,
    input  md_result, md_exception, md_resultRDY,
    output stall, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output wb_valid, wb_rd, wb_data, wb_exception
  );
endinterface
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl
// Description : Issues one mult/div to the shared multdiv unit, stalls until
//               ready or watchdog expiry, then presents a one-cycle writeback
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input wire                  clock,
  input wire                  reset,
  multdiv_issue_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last WAIT count before the counter would reach TIMEOUT.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [4:0]       r_rd;
  logic             r_is_div;
  logic [31:0]      r_wb_data;
  logic [4:0]       r_wb_rd;
  logic             r_wb_exc;

  logic w_accept;
  logic w_rdy_ok;
  logic w_timeout;
  logic w_stall;
  logic w_ctrl_mult;
  logic w_ctrl_div;
  logic w_wb_valid;

  assign w_accept  = (r_state == S_IDLE) && io_bus.req_valid && !io_bus.flush;
  // A ready seen while the counter is still 0 belongs to the previous operation.
  assign w_rdy_ok  = (r_state == S_WAIT) && io_bus.md_resultRDY && (r_cnt != '0);
  assign w_timeout = (r_state == S_WAIT) && !w_rdy_ok && (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_ctrl_mult = 1'b0;
    w_ctrl_div  = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = io_bus.req_valid;
        if (io_bus.req_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_stall     = 1'b1;
        w_ctrl_mult = !r_is_div && !io_bus.flush;
        w_ctrl_div  = r_is_div && !io_bus.flush;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (w_rdy_ok || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_wb_valid  = !io_bus.flush;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (io_bus.flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_is_div  <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_exc  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a   <= io_bus.req_a;
        r_op_b   <= io_bus.req_b;
        r_rd     <= io_bus.req_rd;
        r_is_div <= io_bus.req_is_div;
        r_cnt    <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (!io_bus.flush && w_rdy_ok) begin
        r_wb_data <= io_bus.md_result;
        r_wb_exc  <= io_bus.md_exception;
        r_wb_rd   <= r_rd;
      end else if (!io_bus.flush && w_timeout) begin
        r_wb_data <= '0;
        r_wb_exc  <= 1'b1;
        r_wb_rd   <= r_rd;
      end
    end
  end

  assign io_bus.stall        = w_stall;
  assign io_bus.busy         = (r_state != S_IDLE);
  assign io_bus.md_operandA  = r_op_a;
  assign io_bus.md_operandB  = r_op_b;
  assign io_bus.md_ctrl_MULT = w_ctrl_mult;
  assign io_bus.md_ctrl_DIV  = w_ctrl_div;
  assign io_bus.wb_valid     = w_wb_valid;
  assign io_bus.wb_rd        = r_wb_rd;
  assign io_bus.wb_data      = r_wb_data;
  assign io_bus.wb_exception = r_wb_exc;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_issue_ctrl
// Description : Self-checking bench: vector table, corner sequences, random run
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multdiv_issue_ctrl_if bus ();

  multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // stimulus for the next cycle
  logic        t_rst, t_rv, t_div, t_fl;
  logic [31:0] t_a, t_b;
  logic [4:0]  t_rd;
  bit          rnd_mode = 1'b0;

  // multdiv stub: ready/result stay up until two cycles after the next start
  int          sb_pc   = -1;
  int          sb_lat  = 2;
  bit          sb_hang = 1'b0;
  logic        sb_rdy  = 1'b0;
  logic [31:0] sb_res  = '0;
  logic        sb_exc  = 1'b0;
  logic [31:0] sb_new  = '0;
  logic        sb_new_exc = 1'b0;

  // reference model: acceptance cycle and DONE cycle of the in-flight operation
  int          m_acc  = -1;
  int          m_done = -1;
  logic [31:0] m_a = '0, m_b = '0, m_wbd = '0;
  logic [4:0]  m_rd = '0, m_wbrd = '0;
  logic        m_div = 1'b0, m_wbe = 1'b0;

  // observations of the most recent cycle
  logic        o_stall, o_busy, o_mult, o_div, o_wbv, o_wbe;
  logic [31:0] o_wbd, o_opa, o_opb;
  logic [4:0]  o_wbrd;
  int          o_cyc;

  function automatic void calc(input logic div, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output logic e);
    if (div) begin
      if (b == 32'd0) begin r = 32'd0; e = 1'b1; end
      else            begin r = a / b; e = 1'b0; end
    end else begin
      r = a * b;
      e = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic e_stall, e_busy, e_mult, e_div, e_wbv;
    int d;
    @(posedge clock);
    #1;
    if (sb_pc >= 0 && cyc - sb_pc >= 2) begin
      if (!sb_hang && cyc - sb_pc >= sb_lat) begin
        sb_rdy = 1'b1; sb_res = sb_new; sb_exc = sb_new_exc;
      end else begin
        sb_rdy = 1'b0;
      end
    end
    reset            = t_rst;
    bus.req_valid    = t_rv;
    bus.req_is_div   = t_div;
    bus.req_a        = t_a;
    bus.req_b        = t_b;
    bus.req_rd       = t_rd;
    bus.flush        = t_fl;
    bus.md_resultRDY = sb_rdy;
    bus.md_result    = sb_res;
    bus.md_exception = sb_exc;
    #1;
    o_stall = bus.stall;        o_busy = bus.busy;
    o_mult  = bus.md_ctrl_MULT; o_div  = bus.md_ctrl_DIV;
    o_wbv   = bus.wb_valid;     o_wbe  = bus.wb_exception;
    o_wbd   = bus.wb_data;      o_wbrd = bus.wb_rd;
    o_opa   = bus.md_operandA;  o_opb  = bus.md_operandB;

    e_stall = 1'b0; e_busy = 1'b0; e_mult = 1'b0; e_div = 1'b0; e_wbv = 1'b0;
    if (m_done == cyc) begin
      e_busy = 1'b1;
      e_wbv  = !t_fl;
    end else if (m_acc >= 0) begin
      e_busy  = 1'b1;
      e_stall = 1'b1;
      if (cyc - m_acc == 1) begin
        e_mult = !t_fl && !m_div;
        e_div  = !t_fl && m_div;
      end
    end else begin
      e_stall = t_rv;
    end
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("busy", 32'(o_busy), 32'(e_busy));
    chk("ctrl_MULT", 32'(o_mult), 32'(e_mult));
    chk("ctrl_DIV", 32'(o_div), 32'(e_div));
    chk("wb_valid", 32'(o_wbv), 32'(e_wbv));
    chk("operandA", o_opa, m_a);
    chk("operandB", o_opb, m_b);
    if (e_wbv) begin
      chk("wb_rd", 32'(o_wbrd), 32'(m_wbrd));
      chk("wb_data", o_wbd, m_wbd);
      chk("wb_exception", 32'(o_wbe), 32'(m_wbe));
    end

    if (o_mult || o_div) begin
      sb_pc = cyc;
      calc(o_div, o_opa, o_opb, sb_new, sb_new_exc);
      if (rnd_mode) sb_hang = ($urandom_range(0, 15) == 0);
    end

    if (t_rst) begin
      m_acc = -1; m_done = -1;
      m_a = '0; m_b = '0; m_rd = '0; m_div = 1'b0;
      m_wbd = '0; m_wbe = 1'b0; m_wbrd = '0;
    end else if (t_fl) begin
      m_acc = -1; m_done = -1;
    end else if (m_done == cyc) begin
      m_acc = -1; m_done = -1;
    end else if (m_acc >= 0) begin
      d = cyc - m_acc;
      if (d >= 3 && sb_rdy) begin
        m_done = cyc + 1;
        calc(m_div, m_a, m_b, m_wbd, m_wbe);
        m_wbrd = m_rd;
      end else if (d == TIMEOUT + 1) begin
        m_done = cyc + 1;
        m_wbd = '0; m_wbe = 1'b1; m_wbrd = m_rd;
      end
    end else if (t_rv) begin
      m_acc = cyc;
      m_a = t_a; m_b = t_b; m_rd = t_rd; m_div = t_div;
    end
    o_cyc = cyc;
    cyc++;
  endtask

  // Issues one operation from IDLE and follows it to writeback.
  task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input bit hang,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                        input string tag);
    int acc;
    int np_m;
    int np_d;
    bit seen;
    sb_lat = lat; sb_hang = hang;
    t_div = div; t_a = a; t_b = b; t_rd = rd; t_rv = 1'b1; t_fl = 1'b0; t_rst = 1'b0;
    tick();
    acc = o_cyc;
    chk({tag, "_accept_busy"}, 32'(o_busy), 32'd0);
    t_rv = 1'b0;
    np_m = 0; np_d = 0; seen = 1'b0;
    for (int k = 0; k < TIMEOUT + 10 && !seen; k++) begin
      tick();
      np_m += int'(o_mult);
      np_d += int'(o_div);
      if (o_wbv) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(o_cyc - acc), 32'(exp_lat));
      chk({tag, "_data"}, o_wbd, exp_d);
      chk({tag, "_exc"}, 32'(o_wbe), 32'(exp_e));
      chk({tag, "_rd"}, 32'(o_wbrd), 32'(rd));
      chk({tag, "_mult_pulses"}, 32'(np_m), div ? 32'd0 : 32'd1);
      chk({tag, "_div_pulses"}, 32'(np_d), div ? 32'd1 : 32'd0);
    end
  endtask

  typedef struct {
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    bit          hang;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a0, done1, nwb;
    vt[0] = '{1'b0, 32'd6,          32'd7,  5'd5,  3, 1'b0, 32'd42,          1'b0, 5};
    vt[1] = '{1'b1, 32'd100,        32'd7,  5'd9,  4, 1'b0, 32'd14,          1'b0, 6};
    vt[2] = '{1'b1, 32'd9,          32'd0,  5'd10, 2, 1'b0, 32'd0,           1'b1, 4};
    vt[3] = '{1'b0, 32'd3,          32'd4,  5'd0,  5, 1'b0, 32'd12,          1'b0, 7};
    vt[4] = '{1'b0, 32'hFFFF_FFFF,  32'd2,  5'd31, 2, 1'b0, 32'hFFFF_FFFE,   1'b0, 4};
    vt[5] = '{1'b1, 32'hFFFF_FFFF,  32'h10, 5'd17, 6, 1'b0, 32'h0FFF_FFFF,   1'b0, 8};
    vt[6] = '{1'b0, 32'd8,          32'd8,  5'd12, 2, 1'b1, 32'd0,           1'b1, TIMEOUT + 2};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_is_div = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.req_rd = '0; bus.flush = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    t_rst = 1'b1; t_rv = 1'b0; t_div = 1'b0; t_fl = 1'b0; t_a = '0; t_b = '0; t_rd = '0;

    tick();
    t_rv = 1'b1;
    tick();
    chk("reset_stall_follows_req", 32'(o_stall), 32'd1);
    t_rst = 1'b0; t_rv = 1'b0;
    tick();
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_wb_rd", 32'(o_wbrd), 32'd0);
    chk("reset_wb_data", o_wbd, 32'd0);
    chk("reset_wb_exc", 32'(o_wbe), 32'd0);
    chk("reset_opA", o_opa, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].div, vt[i].a, vt[i].b, vt[i].rd, vt[i].lat, vt[i].hang,
             vt[i].exp_d, vt[i].exp_e, vt[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Stale ready rejection and back-to-back acceptance with req_valid held high
    sb_lat = 2; sb_hang = 1'b0;
    t_div = 1'b0; t_a = 32'd5; t_b = 32'd5; t_rd = 5'd3; t_rv = 1'b1;
    tick();
    a0 = o_cyc;
    t_a = 32'd2; t_b = 32'd9; t_rd = 5'd4;
    done1 = -1;
    for (int k = 0; k < 20 && done1 < 0; k++) begin
      tick();
      if (o_wbv) done1 = o_cyc;
    end
    chk("stale_latency", 32'(done1 - a0), 32'd4);
    chk("stale_data", o_wbd, 32'd25);
    tick();
    chk("b2b_idle_busy", 32'(o_busy), 32'd0);
    chk("b2b_idle_stall", 32'(o_stall), 32'd1);
    tick();
    chk("b2b_issue_pulse", 32'(o_mult), 32'd1);
    t_rv = 1'b0;
    a0 = -1;
    for (int k = 0; k < 20 && a0 < 0; k++) begin
      tick();
      if (o_wbv) a0 = o_cyc;
    end
    chk("b2b_latency", 32'(a0 - done1), 32'd5);
    chk("b2b_data", o_wbd, 32'd18);
    chk("b2b_rd", 32'(o_wbrd), 32'd4);

    // Flush in WAIT at counter 10, then a normal multiply
    sb_hang = 1'b1;
    t_div = 1'b0; t_a = 32'd11; t_b = 32'd13; t_rd = 5'd7; t_rv = 1'b1;
    tick();
    t_rv = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    t_fl = 1'b1;
    tick();
    t_fl = 1'b0;
    tick();
    chk("flush_busy", 32'(o_busy), 32'd0);
    chk("flush_stall", 32'(o_stall), 32'd0);
    nwb = int'(o_wbv);
    for (int k = 0; k < 5; k++) begin
      tick();
      nwb += int'(o_wbv);
    end
    chk("flush_no_wb", 32'(nwb), 32'd0);
    run_op(1'b0, 32'd3, 32'd4, 5'd6, 3, 1'b0, 32'd12, 1'b0, 5, "post_flush");

    // Reset in WAIT
    sb_lat = 8; sb_hang = 1'b0;
    t_div = 1'b1; t_a = 32'd77; t_b = 32'd3; t_rd = 5'd21; t_rv = 1'b1;
    tick();
    t_rv = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    t_rst = 1'b1;
    tick();
    t_rst = 1'b0;
    tick();
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_stall", 32'(o_stall), 32'd0);
    chk("rst_mid_ctrl", 32'({o_mult, o_div}), 32'd0);
    chk("rst_mid_wbv", 32'(o_wbv), 32'd0);
    chk("rst_mid_wb_rd", 32'(o_wbrd), 32'd0);
    chk("rst_mid_wb_data", o_wbd, 32'd0);
    chk("rst_mid_wb_exc", 32'(o_wbe), 32'd0);
    chk("rst_mid_opA", o_opa, 32'd0);
    chk("rst_mid_opB", o_opb, 32'd0);

    // Randomized traffic against the reference model
    rnd_mode = 1'b1;
    for (int k = 0; k < 600; k++) begin
      t_rst  = ($urandom_range(0, 99) == 0);
      t_fl   = ($urandom_range(0, 39) == 0);
      t_rv   = ($urandom_range(0, 2) != 0);
      t_div  = 1'($urandom_range(0, 1));
      t_a    = $urandom;
      t_b    = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 50));
      t_rd   = 5'($urandom_range(0, 31));
      sb_lat = int'($urandom_range(2, 7));
      tick();
    end
    rnd_mode = 1'b0;
    t_rst = 1'b0; t_fl = 1'b0; t_rv = 1'b0; sb_hang = 1'b0;
    for (int k = 0; k < TIMEOUT + 4; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
